axi_wr_responder: RTL and testbench
===================================

AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

Interface
REQ-001 Parameter: ADDR_W, 8, byte-address width; memory depth is 2^ADDR_W entries.
REQ-002 Parameter: DATA_W, 8, write-data beat width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 AWVALID  input  1  write-address valid from initiator.
REQ-006 AWREADY  output  1  write-address accept.
REQ-007 AWADDR  input  ADDR_W  burst start address.
REQ-008 AWLEN  input  4  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-009 AWID  input  4  transaction ID.
REQ-010 WVALID  input  1  write-data valid.
REQ-011 WREADY  output  1  write-data accept.
REQ-012 WDATA  input  DATA_W  write-data beat.
REQ-013 WLAST  input  1  final beat marker from initiator.
REQ-014 BVALID  output  1  write-response valid.
REQ-015 BREADY  input  1  write-response accept.
REQ-016 BID  output  4  echoed AWID.
REQ-017 BRESP  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-018 dbg_addr  input  ADDR_W  debug read address.
REQ-019 dbg_data  output  DATA_W  combinational memory contents at dbg_addr.

Function
REQ-020 The block SHALL implement a three-state FSM: IDLE, DATA, RESP.
REQ-021 IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID&AWREADY latch AWADDR, AWLEN, AWID, clear beat counter and error flag, go to DATA next cycle.
REQ-022 AWREADY SHALL be 0 in DATA and RESP; no second address is accepted until the response completes.
REQ-023 DATA: WREADY=1; each cycle with WVALID&WREADY is one beat; WVALID low inserts a wait with no state change.
REQ-024 Each accepted beat SHALL write WDATA to mem[addr] while beat count <= latched AWLEN, then increment addr by 1 modulo 2^ADDR_W (255 wraps to 0) and increment beat count.
REQ-025 Beats accepted after count exceeds AWLEN SHALL NOT write memory and SHALL set the error flag.
REQ-026 WLAST on a beat whose count != AWLEN SHALL set the error flag; the beat itself is written if count <= AWLEN.
REQ-027 The burst SHALL end only on a beat with WLAST=1; FSM moves to RESP the following cycle.
REQ-028 RESP: BVALID=1, BID=latched AWID, BRESP=2'b10 if error flag else 2'b00; outputs held stable until BREADY.
REQ-029 On BVALID&BREADY the FSM SHALL return to IDLE next cycle, with AWREADY=1 that cycle (one idle cycle minimum between bursts).
REQ-030 BREADY held high in advance SHALL complete the response in the first RESP cycle.
REQ-031 Latency: AW handshake cycle N -> WREADY high at N+1; last beat at cycle M -> BVALID high at M+1.
REQ-032 Beat counter SHALL be 5 bits so 16 legal beats plus overrun detection do not alias.
REQ-033 dbg_data SHALL reflect writes from the cycle after the write edge.

Reset
REQ-034 rst low SHALL immediately force FSM to IDLE, AWREADY=1 after release with no clock edge required, WREADY=0, BVALID=0, BID=0, BRESP=0, counters and latches to 0.
REQ-035 Memory SHALL be cleared to all zeros on reset.
REQ-036 Reset asserted mid-burst or mid-response SHALL abandon the transaction with no response issued; beats written before reset are lost to the clear.

Verification
REQ-037 AWADDR=1, AWLEN=2, AWID=1, beats 0x01,0x02,0x03 with WLAST on third -> mem[1..3]=01,02,03; BVALID one cycle after beat 3, BID=1, BRESP=00.
REQ-038 AWADDR=0xFE, AWLEN=3, beats A0..A3 -> mem[FE]=A0, mem[FF]=A1, mem[00]=A2, mem[01]=A3; BRESP=00.
REQ-039 AWLEN=2, WLAST on second beat -> two bytes written, burst ends, BRESP=10.
REQ-040 AWLEN=0, four beats with WLAST only on fourth -> only first beat written, BRESP=10.
REQ-041 WVALID toggled 1-0-1 and BREADY held low 3 cycles in RESP -> no lost beats; BVALID/BID/BRESP stable until BREADY.
REQ-042 rst pulsed low after second beat of 4-beat burst -> AWREADY=1, BVALID=0, dbg_data=0 at every address; a new burst then completes normally.

Source files
------------

// File: rtl/axi_wr_responder.sv
// AXI-style write responder: one outstanding burst, incrementing writes into a
// register-file memory that can be read combinationally through a debug port.
module axi_wr_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [3:0]        AWID,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [3:0]        BID,
    output logic [1:0]        BRESP,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          id_q, id_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range;
    assign in_range = (cnt_q <= {1'b0, len_q});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (AWVALID) begin
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    id_d    = AWID;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (WVALID) begin
                    if (in_range) begin
                        mem_we = 1'b1;
                        addr_d = addr_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (WLAST && (cnt_q != {1'b0, len_q}))
                        err_d = 1'b1;
                    // Saturate so a long overrun can never wrap back into range.
                    if (cnt_q != 5'd31)
                        cnt_d = cnt_q + 5'd1;
                    if (WLAST)
                        state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (BREADY)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[addr_q] <= WDATA;
        end
    end

    assign AWREADY  = (state_q == S_IDLE);
    assign WREADY   = (state_q == S_DATA);
    assign BVALID   = (state_q == S_RESP);
    assign BID      = (state_q == S_RESP) ? id_q : 4'd0;
    assign BRESP    = (state_q == S_RESP && err_q) ? 2'b10 : 2'b00;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_axi_wr_responder.sv
// Scoreboarded bench: bursts push expected B responses and update a memory
// model; a negedge monitor pops and compares on every B handshake.
module tb_axi_wr_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       AWVALID = 1'b0, AWREADY;
    logic [7:0] AWADDR = '0;
    logic [3:0] AWLEN = '0, AWID = '0;
    logic       WVALID = 1'b0, WREADY, WLAST = 1'b0;
    logic [7:0] WDATA = '0;
    logic       BVALID, BREADY = 1'b0;
    logic [3:0] BID;
    logic [1:0] BRESP;
    logic [7:0] dbg_addr = '0, dbg_data;

    axi_wr_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } rsp_t;

    int         checks = 0;
    int         passes = 0;
    rsp_t       exp_q[$];
    logic [7:0] model [256];
    logic [7:0] wdat  [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string name);
        int         bad = 0;
        logic [7:0] ba = '0, bg = '0, be = '0;
        for (int a = 0; a < 256; a++) begin
            dbg_addr = 8'(a);
            #1;
            if (dbg_data !== model[a] && bad == 0) begin
                bad = 1; ba = 8'(a); bg = dbg_data; be = model[a];
            end
        end
        checks++;
        if (bad == 0) passes++;
        else $display("FAIL %s: mem[%0h] got %0h expected %0h", name, ba, bg, be);
    endtask

    task automatic aw_hs(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id);
        logic hs;
        int   t = 0;
        step();
        AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id;
        forever begin
            @(negedge clk);
            hs = AWREADY;
            step();
            if (hs) break;
            if (++t > 20) begin chk("aw_timeout", 0, 1); break; end
        end
        AWVALID = 1'b0;
        AWADDR  = 8'($urandom);
        chk("wready_latency", 32'(WREADY), 1);
    endtask

    // gaps: 0 none, 1 one idle cycle before every beat after the first, 2 random.
    // bdly: -1 BREADY raised before the last beat, else cycles of BREADY low in RESP.
    task automatic burst(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input int n, input int gaps, input int bdly);
        rsp_t e;
        for (int i = 0; i < n && i <= int'(len); i++)
            model[8'(int'(addr) + i)] = wdat[i];
        e.id   = id;
        e.resp = (n == int'(len) + 1) ? 2'b00 : 2'b10;
        exp_q.push_back(e);

        aw_hs(addr, len, id);
        BREADY = (bdly < 0);
        for (int i = 0; i < n; i++) begin
            if ((gaps == 1 && i > 0) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
                WVALID = 1'b0; WDATA = 8'($urandom); WLAST = 1'($urandom);
                repeat (gaps == 1 ? 1 : $urandom_range(1, 2)) step();
            end
            WVALID = 1'b1; WDATA = wdat[i]; WLAST = (i == n - 1);
            step();
        end
        WVALID = 1'b0; WLAST = 1'b0; WDATA = 8'($urandom);
        chk("bvalid_latency", 32'(BVALID), 1);
        if (bdly >= 0) begin
            repeat (bdly) step();
            BREADY = 1'b1;
        end
        step();
        BREADY = 1'b0;
        chk("idle_after_b", 32'({AWREADY, BVALID, WREADY}), 32'b100);
        sweep("mem_contents");
    endtask

    // Monitor: compare on each B handshake, and demand stable B outputs while stalled.
    logic hold = 1'b0;
    rsp_t held, mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold)
                chk("b_stable", 32'({BVALID, BID, BRESP}), 32'({1'b1, held}));
            if (BVALID && BREADY) begin
                if (exp_q.size() == 0) begin
                    chk("b_unexpected", 32'({BID, BRESP}), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("b_resp", 32'({BID, BRESP}), 32'(mon_e));
                end
            end
            hold = BVALID && !BREADY;
            held = {BID, BRESP};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: run did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 256; a++) model[a] = 8'h00;

        // Reset: outputs valid right after release, before any clock edge.
        #3 rst = 1'b1;
        #1 chk("reset_outputs", 32'({AWREADY, WREADY, BVALID, BID, BRESP}), 32'h100);
        sweep("reset_mem");

        wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
        burst(8'h01, 4'd2, 4'd1, 3, 0, 0);

        for (int i = 0; i < 4; i++) wdat[i] = 8'hA0 + 8'(i);
        burst(8'hFE, 4'd3, 4'd2, 4, 0, -1);

        wdat[0] = 8'h11; wdat[1] = 8'h22;
        burst(8'h10, 4'd2, 4'd3, 2, 0, 1);

        for (int i = 0; i < 4; i++) wdat[i] = 8'h30 + 8'(i);
        burst(8'h20, 4'd0, 4'd4, 4, 0, 2);

        for (int i = 0; i < 4; i++) wdat[i] = 8'h50 + 8'(i);
        burst(8'h40, 4'd3, 4'd5, 4, 1, 3);

        // Reset mid-burst: transaction abandoned, memory cleared.
        aw_hs(8'h80, 4'd3, 4'd6);
        WVALID = 1'b1; WDATA = 8'h77; WLAST = 1'b0; step();
        WDATA = 8'h78; step();
        WVALID = 1'b0;
        rst = 1'b0;
        #1 chk("midreset_outputs", 32'({AWREADY, WREADY, BVALID}), 32'b100);
        for (int a = 0; a < 256; a++) model[a] = 8'h00;
        rst = 1'b1;
        #1 chk("release_outputs", 32'({AWREADY, WREADY, BVALID, BID, BRESP}), 32'h100);
        sweep("midreset_mem");

        for (int i = 0; i < 4; i++) wdat[i] = 8'hC0 + 8'(i);
        burst(8'h80, 4'd3, 4'd7, 4, 0, 0);

        for (int b = 0; b < 30; b++) begin
            logic [3:0] len;
            int         n;
            len = 4'($urandom);
            n   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : int'(len) + 1;
            for (int i = 0; i < 32; i++) wdat[i] = 8'($urandom);
            burst(8'($urandom), len, 4'($urandom), n, 2, int'($urandom_range(0, 4)) - 1);
        end

        step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
